if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage that owns the architectural PC register and consumes the next-PC value produced by the NPC stage. It issues one request at a time to instruction memory over a request/grant plus response-valid handshake. It holds the returned instruction and its PC for decode until decode accepts it, then loads the next PC. It turns the single-cycle datapath into a stallable front end and supports variable-latency instruction memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset.

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- npc_i  in  32  next PC from NPC stage; sampled only on decode handshake
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address, equals pc_o
- imem_gnt_i  in  1  memory accepts request this cycle
- imem_rvalid_i  in  1  response data valid; at most one response per grant, in order
- imem_rdata_i  in  32  response instruction word
- inst_valid_o  out  1  inst_o/pc_o valid for decode
- inst_o  out  32  held instruction word
- pc_o  out  32  PC of current/pending fetch; drives NPC pc_i
- inst_ready_i  in  1  decode accepts the instruction
- fault_o  out  1  misaligned-fetch fault, sticky; only with IF_MISALIGN_CHECK_EN

## Operation
- States: IDLE, REQ, WAIT, HOLD, and FAULT (macro only). State is held in a register.
- IDLE: entered on reset. Goes to REQ on the next clock edge unconditionally.
- REQ: imem_req_o=1 and imem_addr_o=pc_o. On imem_gnt_i, go to WAIT. Otherwise stay; address is stable while waiting.
- WAIT: imem_req_o=0. On imem_rvalid_i, register imem_rdata_i into inst_o and go to HOLD.
- HOLD: inst_valid_o=1. inst_o and pc_o are stable. On inst_ready_i, load pc_o<=npc_i and go to REQ.
- imem_rvalid_i outside WAIT is ignored. This includes a stale response arriving after reset.
- imem_gnt_i outside REQ is ignored.
- Only one request is outstanding at any time. No speculative prefetch.
- Reset in any state, including mid-WAIT, aborts the fetch:
  - pc_o=RESET_PC, inst_o=0, state IDLE.
  - No pending response is honoured afterwards.
- PC arithmetic is 32-bit. Loading npc_i wraps naturally; there is no overflow detection.

## Timing
- Reset values:
  - pc_o=RESET_PC, imem_addr_o=RESET_PC
  - imem_req_o=0, inst_valid_o=0, inst_o=32'h0, fault_o=0
- All outputs decode directly from registers. There is no combinational path from any input to any output.
- The first imem_req_o assertion is in the first cycle after reset deasserts (IDLE→REQ edge).
- Minimum fetch-to-fetch interval, with gnt on first REQ cycle, rvalid on first WAIT cycle, and ready on first HOLD cycle: 3 cycles.
  - Cycle N: REQ.
  - Cycle N+1: WAIT.
  - Cycle N+2: HOLD.
  - Cycle N+3: REQ at the new PC.
- Memory latency L cycles from grant to rvalid gives L extra WAIT cycles.
- Decode backpressure extends HOLD indefinitely with outputs frozen.
- npc_i is sampled only on the edge ending the HOLD cycle in which inst_ready_i=1. Its value in other cycles is don't-care.

## Configuration
- IF_MISALIGN_CHECK_EN defined:
  - On the HOLD handshake, if npc_i[1:0]≠2'b00, load pc_o<=npc_i and enter FAULT.
  - FAULT: fault_o=1, imem_req_o=0, inst_valid_o=0. Held until reset.
- IF_MISALIGN_CHECK_EN undefined:
  - pc_o loads {npc_i[31:2],2'b00}.
  - fault_o is tied to 0 and FAULT does not exist.

## Structure
- State encodings (IDLE/REQ/WAIT/HOLD/FAULT) and the default RESET_PC go in the shared param.v include alongside the NPC op encodings.
- Sub-module: pc_reg, a 32-bit async-reset register with load enable and reset value RESET_PC. It is instantiated once for pc_o.
- inst_o capture and the FSM stay in if_fetch.

## Test plan
- Reset, then memory with gnt in same cycle and rvalid next cycle, ready always 1, npc_i=pc_o+4:
  - Addresses are 0,4,8 at 3-cycle spacing.
  - inst_o matches memory contents.
- gnt delayed 2 cycles and rvalid delayed 3 cycles: imem_addr_o stays stable through REQ, and exactly one capture occurs per grant.
- inst_ready_i=0 for 5 cycles in HOLD: inst_valid_o=1, inst_o/pc_o frozen, imem_req_o=0, and npc_i changes are ignored.
- Reset asserted mid-WAIT at pc=0x40, then a stale rvalid with 0xDEADBEEF 1 cycle after release: it is ignored, and the fetch restarts at RESET_PC.
- npc_i=0x102 at the handshake:
  - With macro: fault_o=1, pc_o=0x102, no further requests.
  - Without macro: next fetch address is 0x100.
- Jump to npc_i=0xFFFF_FFFC, then 0x0: both fetched correctly, with no wrap artefacts.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the fetch front end: FSM encodings, the default reset PC and NPC op codes.
package if_fetch_pkg;

    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        NPC_OP_PC4    = 2'd0,
        NPC_OP_BRANCH = 2'd1,
        NPC_OP_JAL    = 2'd2,
        NPC_OP_JALR   = 2'd3
    } npc_op_t;

    // Force a byte address onto a word boundary.
    function automatic logic [DATA_W-1:0] align_word(input logic [DATA_W-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_fetch_pc_reg.sv
// Architectural PC register: async-reset to a configurable value, loads only when enabled.
module pc_reg
    import if_fetch_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_VAL = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Stallable instruction-fetch stage: one outstanding request, holds the fetched word until decode takes it.
// Optional misaligned-fetch fault enabled by defining IF_MISALIGN_CHECK_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] npc_i,
    output logic              imem_req_o,
    output logic [DATA_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [DATA_W-1:0] pc_o,
    input  logic              inst_ready_i,
    output logic              fault_o
);

    fetch_state_t      state, state_nxt;
    logic              pc_load;
    logic              inst_cap;
    logic [DATA_W-1:0] pc_nxt;
    logic [DATA_W-1:0] inst_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Responses and grants are only honoured in the state that expects them,
    // so a response still in flight across a reset is silently dropped.
    always_comb begin
        state_nxt = state;
        pc_load   = 1'b0;
        inst_cap  = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ: begin
                if (imem_gnt_i) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    inst_cap  = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_ready_i) begin
                    pc_load = 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
                    state_nxt = (npc_i[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
`else
                    state_nxt = ST_REQ;
`endif
                end
            end
`ifdef IF_MISALIGN_CHECK_EN
            ST_FAULT: state_nxt = ST_FAULT;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef IF_MISALIGN_CHECK_EN
    assign pc_nxt = npc_i;
`else
    assign pc_nxt = align_word(npc_i);
`endif

    pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_nxt),
        .q     (pc_o)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_q <= '0;
        end else if (inst_cap) begin
            inst_q <= imem_rdata_i;
        end
    end

    assign inst_o       = inst_q;
    assign imem_addr_o  = pc_o;
    assign imem_req_o   = (state == ST_REQ);
    assign inst_valid_o = (state == ST_HOLD);
`ifdef IF_MISALIGN_CHECK_EN
    assign fault_o      = (state == ST_FAULT);
`else
    assign fault_o      = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: transaction-level model of PC flow and memory, randomized handshakes.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] npc_i = 32'h0;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        inst_ready_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        fault_o;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .npc_i         (npc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .inst_ready_i  (inst_ready_i),
        .fault_o       (fault_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: expected PC, whether a fetch is in flight, and what must show up this cycle.
    logic [31:0] exp_pc = 32'h0;
    bit          outstanding = 1'b0;
    int          lat = 0;
    bit          must_req = 1'b0;
    bit          must_valid = 1'b0;
    bit          was_rst = 1'b1;
    bit          faulted = 1'b0;
    int          handshakes = 0;

    // What was applied / observed during the cycle that just ended.
    bit          c_rst = 1'b1;
    bit          c_gnt = 1'b0;
    bit          c_rv_real = 1'b0;
    bit          c_ready = 1'b0;
    logic [31:0] c_npc = 32'h0;
    bit          o_req = 1'b0;
    bit          o_valid = 1'b0;

    // Stimulus knobs.
    int gnt_mode = 0;
    int lat_mode = 0;
    int ready_mode = 0;
    int npc_mode = 0;
    int ready_hold = 0;
    int req_cnt = 0;
    bit force_rst = 1'b1;
    bit junk_en = 1'b0;
    bit inject_stale = 1'b0;
    bit jump_armed = 1'b0;

    logic [31:0] npc_q[$];
    logic [31:0] jump_q[$];
    logic [31:0] start_addr_q[$];
    int          start_cyc_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input bit act, input bit exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0b required=%0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit          gnt;
        bit          rdy;
        bit          rv;
        logic [31:0] rdata;
        logic [31:0] npc;
        @(posedge clk);
        #1;
        cyc++;

        if (c_rst) begin
            exp_pc      = 32'h0;
            outstanding = 1'b0;
            must_req    = 1'b0;
            must_valid  = 1'b0;
            was_rst     = 1'b1;
            faulted     = 1'b0;
        end else begin
            must_req   = was_rst;
            must_valid = 1'b0;
            was_rst    = 1'b0;
            if (o_req && c_gnt) begin
                outstanding = 1'b1;
                lat = (lat_mode < 0) ? int'($urandom_range(3)) : lat_mode;
            end
            if (c_rv_real) begin
                outstanding = 1'b0;
                must_valid  = 1'b1;
            end
            if (o_valid && c_ready) begin
                handshakes++;
`ifdef IF_MISALIGN_CHECK_EN
                exp_pc = c_npc;
                if (c_npc[1:0] != 2'b00) faulted = 1'b1;
                else must_req = 1'b1;
`else
                exp_pc   = c_npc & ~32'h3;
                must_req = 1'b1;
`endif
            end
        end

        if (c_rst) begin
            check1("rst_req", imem_req_o, 1'b0);
            check1("rst_valid", inst_valid_o, 1'b0);
            check1("rst_fault", fault_o, 1'b0);
            check("rst_inst", inst_o, 32'h0);
            check("rst_pc", pc_o, 32'h0);
        end else begin
            check("addr_eq_pc", imem_addr_o, pc_o);
            if (faulted) begin
                check1("fault_flag", fault_o, 1'b1);
                check1("fault_req", imem_req_o, 1'b0);
                check1("fault_valid", inst_valid_o, 1'b0);
                check("fault_pc", pc_o, exp_pc);
            end else begin
                check1("no_fault", fault_o, 1'b0);
                if (must_req) check1("req_on_time", imem_req_o, 1'b1);
                if (must_valid) check1("valid_on_time", inst_valid_o, 1'b1);
                check1("waiting", !imem_req_o && !inst_valid_o, outstanding);
                check1("req_and_valid", imem_req_o && inst_valid_o, 1'b0);
                if (imem_req_o) check("req_addr", imem_addr_o, exp_pc);
                if (inst_valid_o) begin
                    check("hold_pc", pc_o, exp_pc);
                    check("hold_inst", inst_o, mem_word(exp_pc));
                end
                if (must_req && imem_req_o) begin
                    start_addr_q.push_back(imem_addr_o);
                    start_cyc_q.push_back(cyc);
                    if (jump_armed) begin
                        jump_q.push_back(imem_addr_o);
                        jump_armed = 1'b0;
                    end
                end
            end
        end
        o_req   = imem_req_o;
        o_valid = inst_valid_o;

        // Drive the next cycle.
        if (imem_req_o) begin
            gnt = (gnt_mode == 0) || (gnt_mode == 1 && req_cnt >= 2) ||
                  (gnt_mode == 2 && $urandom_range(1) == 1);
            req_cnt++;
        end else begin
            req_cnt = 0;
            gnt = junk_en && ($urandom_range(1) == 1);
        end

        c_rv_real = 1'b0;
        rdata = $urandom;
        if (outstanding && !force_rst) begin
            if (lat == 0) begin
                rv        = 1'b1;
                rdata     = mem_word(exp_pc);
                c_rv_real = 1'b1;
            end else begin
                lat--;
                rv = 1'b0;
            end
        end else if (inject_stale) begin
            rv           = 1'b1;
            rdata        = 32'hDEAD_BEEF;
            inject_stale = 1'b0;
        end else begin
            rv = junk_en && ($urandom_range(3) == 0);
        end

        if (inst_valid_o && ready_hold > 0) begin
            rdy = 1'b0;
            ready_hold--;
        end else begin
            rdy = (ready_mode == 0) || ($urandom_range(1) == 1);
        end

        if (!rdy) begin
            npc = $urandom;
        end else if (inst_valid_o && npc_q.size() > 0) begin
            npc = npc_q.pop_front();
            jump_armed = 1'b1;
        end else if (npc_mode == 0) begin
            npc = exp_pc + 32'd4;
        end else begin
`ifdef IF_MISALIGN_CHECK_EN
            npc = $urandom & ~32'h3;
`else
            npc = $urandom;
`endif
        end

        reset         = force_rst;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rdata;
        inst_ready_i  = rdy;
        npc_i         = npc;
        c_rst         = force_rst;
        c_gnt         = gnt;
        c_ready       = rdy;
        c_npc         = npc;
    endtask

    initial begin
        logic [31:0] held_pc;
        int          hs0;

        #2;
        check("init_pc", pc_o, 32'h0);
        check("init_addr", imem_addr_o, 32'h0);
        check("init_inst", inst_o, 32'h0);
        check1("init_req", imem_req_o, 1'b0);
        check1("init_valid", inst_valid_o, 1'b0);
        check1("init_fault", fault_o, 1'b0);
        repeat (2) step();

        // Back-to-back fetches at the minimum interval.
        start_addr_q.delete();
        start_cyc_q.delete();
        force_rst = 1'b0;
        repeat (12) step();
        check1("seq_count", start_addr_q.size() >= 3, 1'b1);
        if (start_addr_q.size() >= 3) begin
            check("seq_addr0", start_addr_q[0], 32'h0);
            check("seq_addr1", start_addr_q[1], 32'h4);
            check("seq_addr2", start_addr_q[2], 32'h8);
            check("seq_gap01", start_cyc_q[1] - start_cyc_q[0], 32'd3);
            check("seq_gap12", start_cyc_q[2] - start_cyc_q[1], 32'd3);
        end

        // Slow grant and slow memory.
        gnt_mode = 1;
        lat_mode = 3;
        hs0 = handshakes;
        repeat (30) step();
        check1("slow_progress", (handshakes - hs0) >= 3, 1'b1);

        // Decode backpressure for five HOLD cycles.
        gnt_mode   = 0;
        lat_mode   = 0;
        ready_hold = 5;
        for (int i = 0; i < 20 && !inst_valid_o; i++) step();
        check1("bp_reach_hold", inst_valid_o, 1'b1);
        held_pc = exp_pc;
        repeat (4) step();
        check1("bp_valid", inst_valid_o, 1'b1);
        check1("bp_req", imem_req_o, 1'b0);
        check("bp_pc", pc_o, held_pc);
        check("bp_inst", inst_o, mem_word(held_pc));

        // Reset in the middle of a fetch, then a stale response.
        npc_q.push_back(32'h40);
        lat_mode = 20;
        for (int i = 0; i < 40 && !(outstanding && exp_pc == 32'h40); i++) step();
        check1("mid_wait_reached", outstanding && exp_pc == 32'h40, 1'b1);
        force_rst = 1'b1;
        repeat (2) step();
        force_rst = 1'b0;
        step();
        inject_stale = 1'b1;
        lat_mode = 0;
        step();
        check("restart_addr", imem_addr_o, 32'h0);
        for (int i = 0; i < 20 && !inst_valid_o; i++) step();
        check1("restart_valid", inst_valid_o, 1'b1);
        check("restart_pc", pc_o, 32'h0);
        check("restart_inst", inst_o, 32'h1357_6420);

        // Jump to the top of the address space and back to zero.
        jump_q.delete();
        npc_q.push_back(32'hFFFF_FFFC);
        npc_q.push_back(32'h0);
        for (int i = 0; i < 60 && jump_q.size() < 2; i++) step();
        check1("jump_count", jump_q.size() >= 2, 1'b1);
        if (jump_q.size() >= 2) begin
            check("jump_top", jump_q[0], 32'hFFFF_FFFC);
            check("jump_zero", jump_q[1], 32'h0);
        end

        // Random handshakes, junk grants/responses, random next PCs.
        gnt_mode   = 2;
        lat_mode   = -1;
        ready_mode = 1;
        npc_mode   = 1;
        junk_en    = 1'b1;
        hs0 = handshakes;
        repeat (800) step();
        check1("random_progress", (handshakes - hs0) >= 40, 1'b1);

        // Misaligned next PC.
        gnt_mode   = 0;
        lat_mode   = 0;
        ready_mode = 0;
        npc_mode   = 0;
        junk_en    = 1'b0;
        repeat (4) step();
        jump_q.delete();
        npc_q.push_back(32'h102);
`ifdef IF_MISALIGN_CHECK_EN
        for (int i = 0; i < 60 && !faulted; i++) step();
        repeat (3) step();
        check1("mis_fault", fault_o, 1'b1);
        check("mis_pc", pc_o, 32'h102);
        check1("mis_no_req", imem_req_o, 1'b0);
        check1("mis_no_valid", inst_valid_o, 1'b0);
`else
        for (int i = 0; i < 60 && jump_q.size() < 1; i++) step();
        check1("mis_count", jump_q.size() >= 1, 1'b1);
        if (jump_q.size() >= 1) check("mis_aligned_addr", jump_q[0], 32'h100);
        repeat (4) step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
